// File: rtl/rbz_spi_pkg.sv
// rbz_spi_pkg: shared FSM states, command width and raybox-zero register command codes
package rbz_spi_pkg;
    localparam int CMD_W = 4;
    typedef enum logic [2:0] {IDLE, LO, HI, HOLD, GAP} state_t;
    localparam logic [CMD_W-1:0] CMD_SKY     = 4'd0;
    localparam logic [CMD_W-1:0] CMD_FLOOR   = 4'd1;
    localparam logic [CMD_W-1:0] CMD_LEAK    = 4'd2;
    localparam logic [CMD_W-1:0] CMD_OTHER   = 4'd3;
    localparam logic [CMD_W-1:0] CMD_VSHIFT  = 4'd4;
    localparam logic [CMD_W-1:0] CMD_VINF    = 4'd5;
    localparam logic [CMD_W-1:0] CMD_MAPD    = 4'd6;
    localparam logic [CMD_W-1:0] CMD_TEXADD0 = 4'd7;
    localparam logic [CMD_W-1:0] CMD_TEXADD1 = 4'd8;
    localparam logic [CMD_W-1:0] CMD_TEXADD2 = 4'd9;
    localparam logic [CMD_W-1:0] CMD_TEXADD3 = 4'd10;
endpackage

// File: rtl/rbz_spi_tick.sv
// rbz_spi_tick: CLK_DIV phase down-counter; ports i_clk, i_reset, i_reload (restart phase), o_tick (last cycle of phase)
module rbz_spi_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_reload,
    output logic o_tick
);
    logic [7:0] cnt;
    assign o_tick = cnt == 8'd0;
    always_ff @(posedge i_clk) begin
        if (i_reset) cnt <= 8'd0;
        else cnt <= (i_reload || o_tick) ? 8'(CLK_DIV - 1) : cnt - 8'd1;
    end
endmodule

// File: rtl/rbz_spi_reg_writer.sv
// rbz_spi_reg_writer: SPI mode-0 frame sender (4-bit cmd + 0..MAX_BITS payload, MSB-first) for raybox-zero reg/vec SPI.
// Ports: i_clk, i_reset (sync, active high), i_start/i_cmd/i_data/i_len request, o_ready/o_busy/o_done status,
// o_csb/o_sclk/o_mosi SPI. Optional one-entry start buffer with RBZ_SPI_WR_QUEUE_EN.
module rbz_spi_reg_writer
    import rbz_spi_pkg::*;
#(
    parameter int MAX_BITS = 32,
    parameter int CLK_DIV  = 2,
    parameter int LEN_W    = 6
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [CMD_W-1:0]    i_cmd,
    input  logic [MAX_BITS-1:0] i_data,
    input  logic [LEN_W-1:0]    i_len,
    output logic                o_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_csb,
    output logic                o_sclk,
    output logic                o_mosi
);
    localparam int SW = CMD_W + MAX_BITS;
    localparam int BW = $clog2(MAX_BITS + 5);
    state_t state;
    logic tick, go, acc;
    logic [SW-1:0] sh;
    logic [BW-1:0] bcnt;
    logic [CMD_W-1:0] s_cmd;
    logic [MAX_BITS-1:0] s_data;
    logic [LEN_W-1:0] s_len, lenc;
    assign acc = i_start & o_ready;
`ifdef RBZ_SPI_WR_QUEUE_EN
    logic q_v;
    logic [CMD_W-1:0] q_cmd;
    logic [MAX_BITS-1:0] q_data;
    logic [LEN_W-1:0] q_len;
    assign o_ready = ~q_v;
    assign go = (state == IDLE) && (q_v || acc);
    assign s_cmd = q_v ? q_cmd : i_cmd;
    assign s_data = q_v ? q_data : i_data;
    assign s_len = q_v ? q_len : i_len;
    // In IDLE the buffer is either launched or a direct start bypasses it.
    always_ff @(posedge i_clk) begin
        if (i_reset || state == IDLE) q_v <= 1'b0;
        else if (acc) q_v <= 1'b1;
        if (acc) begin
            q_cmd <= i_cmd;
            q_data <= i_data;
            q_len <= i_len;
        end
    end
`else
    assign o_ready = ~o_busy;
    assign go = acc;
    assign s_cmd = i_cmd;
    assign s_data = i_data;
    assign s_len = i_len;
`endif
    assign lenc = (s_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : s_len;
    rbz_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_reload(go),
        .o_tick(tick)
    );
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            o_csb <= 1'b1;
            o_sclk <= 1'b0;
            o_mosi <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    // Payload is left-aligned under the command so the frame shifts out of the top bit.
                    state <= LO;
                    o_csb <= 1'b0;
                    o_mosi <= s_cmd[CMD_W-1];
                    o_busy <= 1'b1;
                    sh <= {s_cmd, s_data << (MAX_BITS - lenc)};
                    bcnt <= BW'(lenc) + BW'(CMD_W - 1);
                end
                LO: if (tick) begin
                    state <= HI;
                    o_sclk <= 1'b1;
                end
                HI: if (tick) begin
                    o_sclk <= 1'b0;
                    if (bcnt != '0) begin
                        state <= LO;
                        sh <= sh << 1;
                        o_mosi <= sh[SW-2];
                        bcnt <= bcnt - 1'b1;
                    end else state <= HOLD;
                end
                HOLD: if (tick) begin
                    state <= GAP;
                    o_csb <= 1'b1;
                    o_mosi <= 1'b0;
                end
                GAP: if (tick) begin
                    state <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rbz_spi_reg_writer.sv
// tb_rbz_spi_reg_writer: randomized self-checking bench against a frame-level SPI reference model
module tb_rbz_spi_reg_writer;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
    logic [3:0] cmd = '0;
    logic [31:0] data = '0;
    logic [5:0] len = '0;
    logic rdy0, bsy0, dn0, csb0, sck0, mo0, rdy1, bsy1, dn1, csb1, sck1, mo1;
    logic rdy, bsy, dn, csb, sck, mo;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    rbz_spi_reg_writer #(.MAX_BITS(32), .CLK_DIV(2), .LEN_W(6)) u0 (
        .i_clk(clk), .i_reset(rst), .i_start(start & ~sel), .i_cmd(cmd), .i_data(data), .i_len(len),
        .o_ready(rdy0), .o_busy(bsy0), .o_done(dn0), .o_csb(csb0), .o_sclk(sck0), .o_mosi(mo0));
    rbz_spi_reg_writer #(.MAX_BITS(32), .CLK_DIV(1), .LEN_W(6)) u1 (
        .i_clk(clk), .i_reset(rst), .i_start(start & sel), .i_cmd(cmd), .i_data(data), .i_len(len),
        .o_ready(rdy1), .o_busy(bsy1), .o_done(dn1), .o_csb(csb1), .o_sclk(sck1), .o_mosi(mo1));
    assign rdy = sel ? rdy1 : rdy0;
    assign bsy = sel ? bsy1 : bsy0;
    assign dn  = sel ? dn1 : dn0;
    assign csb = sel ? csb1 : csb0;
    assign sck = sel ? sck1 : sck0;
    assign mo  = sel ? mo1 : mo0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_csb"}, csb, 1);
        check({tag, "_sclk"}, sck, 0);
        check({tag, "_mosi"}, mo, 0);
        check({tag, "_busy"}, bsy, 0);
        check({tag, "_done"}, dn, 0);
    endtask

    // poke: cycle of a spurious start (0 none); abort: cycle to assert reset (0 none)
    task automatic frame(input logic [3:0] c, input logic [31:0] d, input int l, input int poke, input int abort);
        int lc, n, dv, k, lim, lo, edges, done_at, ndone, viol;
        logic [35:0] exp, got;
        logic prev;
        lc = l > 32 ? 32 : l;
        n = 4 + lc;
        dv = sel ? 1 : 2;
        exp = 36'(c);
        for (int i = lc - 1; i >= 0; i--) exp = (exp << 1) | 36'(d[i]);
        k = 0;
        while (!rdy && k < 1000) begin @(negedge clk); k++; end
        check("ready_wait", rdy, 1);
        cmd = c; data = d; len = 6'(l); start = 1'b1;
        lim = (2 * n + 2) * dv + 3;
        k = 0; lo = 0; edges = 0; done_at = 0; ndone = 0; viol = 0; got = '0; prev = 1'b0;
        while (k < lim) begin
            @(negedge clk);
            k++;
            start = (k == poke);
            cmd = 4'($urandom); data = $urandom; len = 6'($urandom);
            if (k == 1) begin
                check("csb_fall", csb, 0);
                check("busy_rise", bsy, 1);
            end
            if (!csb) lo++;
            if (csb && (sck || mo)) viol++;
            if (sck && !prev) begin edges++; got = {got[34:0], mo}; end
            prev = sck;
            if (dn) begin ndone++; if (done_at == 0) done_at = k; end
            if (abort != 0 && k == abort) begin
                start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle("abort");
                check("abort_ready", rdy, 1);
                repeat (2 * dv + 2) begin @(negedge clk); if (dn) ndone++; end
                check("abort_no_done", ndone, 0);
                return;
            end
        end
        check("bits", got, exp);
        check("edges", edges, n);
        check("csb_low", lo, (2 * n + 1) * dv);
        check("done_at", done_at, (2 * n + 2) * dv + 1);
        check("done_count", ndone, 1);
        check("idle_violations", viol, 0);
    endtask

`ifdef RBZ_SPI_WR_QUEUE_EN
    task automatic queue_test();
        int k, fr, done1, fall2, done2;
        logic [3:0] got [2];
        logic prev_csb, prev_sck;
        got[0] = '0; got[1] = '0;
        cmd = 4'd1; len = 6'd0; start = 1'b1;
        k = 0; fr = -1; done1 = 0; fall2 = 0; done2 = 0; prev_csb = 1'b1; prev_sck = 1'b0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) begin check("q_ready_empty", rdy, 1); cmd = 4'd2; start = 1'b1; end
            else if (k == 2) begin check("q_ready_full", rdy, 0); cmd = 4'd3; start = 1'b1; end
            else start = 1'b0;
            if (prev_csb && !csb) begin fr++; if (fr == 1) fall2 = k; end
            if (sck && !prev_sck && fr >= 0 && fr < 2) got[fr] = {got[fr][2:0], mo};
            if (dn) begin if (done1 == 0) done1 = k; else if (done2 == 0) done2 = k; end
            prev_csb = csb; prev_sck = sck;
        end
        check("q_frames", fr + 1, 2);
        check("q_bits1", got[0], 4'd1);
        check("q_bits2", got[1], 4'd2);
        check("q_done1", done1, 21);
        check("q_fall2", fall2, done1 + 1);
        check("q_done2", done2, done1 + 21);
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_ready", rdy, 1);
        rst = 1'b0;
        @(negedge clk);
        frame(4'hA, 32'b101101, 6, 0, 0);
        frame(4'h3, 32'hFFFF_FFFF, 0, 0, 0);
        frame(4'h5, 32'hDEADBEEF, 40, 0, 0);
        sel = 1'b1;
        frame(4'hC, 32'hDEADBEEF, 40, 0, 0);
        frame(4'h9, 32'h1, 1, 0, 0);
        sel = 1'b0;
`ifndef RBZ_SPI_WR_QUEUE_EN
        frame(4'h6, 32'h0000_0F0F, 12, 7, 0);
        frame(4'h7, 32'h0000_00AA, 8, 0, 0);
`endif
        frame(4'hE, 32'h1234_5678, 20, 0, 22);
        frame(4'h2, 32'h0000_00C3, 8, 0, 0);
        for (int r = 0; r < 20; r++) begin
            sel = 1'($urandom);
            frame(4'($urandom), $urandom, int'($urandom_range(0, 40)), 0, 0);
        end
        sel = 1'b0;
`ifdef RBZ_SPI_WR_QUEUE_EN
        queue_test();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rbz_spi_reg_writer.md
Name: rbz_spi_reg_writer

Overview:
- SPI mode-0 transmitter that drives the raybox-zero register/vector SPI slave inputs (reg_csb/reg_sclk/reg_mosi or vec_csb/vec_sclk/vec_mosi).
- Lets on-chip logic (LA bits, Wishbone glue, self-test) load registers without external pins.
- Sits beside top_design_mux; its outputs are muxed onto the design's SPI inputs in place of IO pads.
- Each frame carries a 4-bit command followed by 0..MAX_BITS payload bits, sent MSB-first.

Parameters:
- MAX_BITS, 32, maximum payload bits per frame.
- CLK_DIV, 2, i_clk cycles per SCLK half-period; legal values are 1..255.
- LEN_W, 6, width of i_len; must satisfy 2^LEN_W > MAX_BITS.

Ports:
- i_clk  input  1  system clock (wb_clk_i in the wrapper).
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request a frame; accepted when i_start & o_ready.
- i_cmd  input  4  command code, sent first.
- i_data  input  MAX_BITS  payload; only bits [i_len-1:0] are used.
- i_len  input  LEN_W  payload bit count.
- o_ready  output  1  a start can be accepted this cycle.
- o_busy  output  1  a frame or gap is in progress.
- o_done  output  1  one-cycle pulse at frame completion.
- o_csb  output  1  SPI chip select, active low.
- o_sclk  output  1  SPI clock; idles low.
- o_mosi  output  1  SPI data out.

Behaviour:
- Reset values: o_csb=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, o_ready=1. State returns to IDLE and the tick counter clears.
- Input capture: on acceptance at edge t0, cmd, data and len are latched. Inputs may then change freely.
- Length handling: N = 4 + min(i_len, MAX_BITS). i_len=0 sends the command only. i_len>MAX_BITS is clamped to MAX_BITS.
- States: IDLE -> LO -> HI -> (LO | HOLD) -> GAP -> IDLE. Every state lasts exactly CLK_DIV cycles.
- IDLE:
  - o_csb=1, o_sclk=0.
  - On accept: at t0+1 o_csb=0, o_mosi=cmd[3], o_busy=1; enter LO.
- LO: o_sclk=0, o_mosi holds the current bit.
- HI:
  - o_sclk=1; the slave samples on the rising edge.
  - On exit with bits remaining: o_sclk goes 0, o_mosi advances to the next bit, enter LO.
  - After the last bit: enter HOLD.
- HOLD: o_sclk=0, o_csb=0; o_mosi keeps the last bit.
- GAP: o_csb=1, o_mosi=0. This is the minimum CSB-high time between frames.
- Completion: o_done=1 for exactly one cycle on GAP exit, in the same cycle o_busy falls and o_ready rises.
- Timing:
  - CSB low time = (2N+1)*CLK_DIV cycles.
  - o_done asserts (2N+2)*CLK_DIV+1 cycles after t0.
  - No SCLK edge occurs while CSB is high.
- Without the queue, o_ready = ~o_busy. i_start while busy is ignored: no effect, no error.
- Reset mid-frame: the next cycle shows reset values, the frame is aborted and no o_done is produced.
- Counters:
  - Bit counter width is clog2(MAX_BITS+5).
  - Tick counter counts CLK_DIV-1 down to 0, then reloads.
  - Nothing wraps inside a frame.

Optional Feature:
- Macro: RBZ_SPI_WR_QUEUE_EN.
- With the macro defined:
  - A one-entry holding buffer is added, so o_ready=1 while busy if the buffer is empty.
  - A start accepted while busy is stored and launched immediately after GAP. Its CSB falls the cycle after o_done.
  - Start accepted on the same cycle as o_done: it is stored in the empty buffer and launched the next cycle.
  - Reset clears the buffer.
- Without the macro: no buffer; o_ready = ~o_busy.

Decomposition:
- Package rbz_spi_pkg holds:
  - state enum (IDLE, LO, HI, HOLD, GAP);
  - CMD_W=4;
  - raybox-zero register command codes (sky, floor, leak, other, vshift, vinf, mapd, texadd0..3).
- Sub-module rbz_spi_tick:
  - CLK_DIV down-counter with a synchronous reload input;
  - emits a one-cycle tick at the end of each phase;
  - shared with any future vector-SPI writer.

Test Plan:
- Basic frame:
  - Stimulus: CLK_DIV=2, cmd=4'hA, len=6, data=6'b101101.
  - Response: the slave model captures 1010_101101; CSB is low for 42 cycles; o_done pulses at t0+45.
- Command-only frame:
  - Stimulus: len=0, cmd=4'h3.
  - Response: exactly 4 rising edges with bits 0011; CSB is low for 18 cycles at CLK_DIV=2.
- Clamp and full length:
  - Stimulus: MAX_BITS=32, len=40, data=32'hDEADBEEF.
  - Response: 36 bits, with payload DEADBEEF MSB-first.
  - Repeat with CLK_DIV=1: CSB low for 73 cycles.
- Busy behaviour (no queue):
  - Stimulus: i_start pulsed mid-frame.
  - Response: ignored; exactly one o_done. A second start after o_done produces a frame whose CSB falls 1 cycle after the accept.
- Reset mid-frame:
  - Stimulus: assert i_reset after bit 5.
  - Response: next cycle o_csb=1, o_sclk=0, o_mosi=0, o_busy=0; no o_done. A fresh frame then completes correctly.
- Queue (RBZ_SPI_WR_QUEUE_EN):
  - Stimulus: two starts back-to-back, cmd 1 then 2.
  - Response: second CSB falls the cycle after the first o_done; both frames decode correctly; a third start while the buffer is full sees o_ready=0.
